// File: rtl/debug_pkg.sv
// Shared definitions for the MIPS debug unit: session states, command bytes,
// acknowledge timeout and frame geometry shared with the frame transmitter.
package debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP      = 3'd2,
    ST_SNAP      = 3'd3,
    ST_SEND_REQ  = 3'd4,
    ST_SEND_WAIT = 3'd5
  } state_t;

  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_DUMP = 8'h44;
  localparam logic [7:0] CMD_HALT = 8'h48;

  localparam int ACK_TIMEOUT_DEF = 1024;

  // Bytes per debug frame; the transmitter serialises this many from the snapshot.
  localparam int FRAME_BYTES = 64;

endpackage

// File: rtl/debug_cmd_decode.sv
// Combinational classification of a received UART byte into debug commands.
import debug_pkg::*;

module debug_cmd_decode (
  input  logic [7:0] rx_data,
  output logic       is_run,
  output logic       is_step,
  output logic       is_dump,
  output logic       is_halt,
  output logic       is_bad
);

  always_comb begin
    is_run  = (rx_data == CMD_RUN);
    is_step = (rx_data == CMD_STEP);
    is_dump = (rx_data == CMD_DUMP);
    is_halt = (rx_data == CMD_HALT);
    is_bad  = !(is_run || is_step || is_dump || is_halt);
  end

endmodule

// File: rtl/debug_session_ctrl.sv
// Debug session sequencer: decodes UART commands, gates the pipeline enable,
// strobes the frame snapshot and handshakes the frame out through the transmitter.
import debug_pkg::*;

module debug_session_ctrl #(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_done_tick,
  input  logic [7:0]  rx_data,
  input  logic        halt_req,
  input  logic        tx_data_sent,
  output logic        cpu_enable,
  output logic        snap_en,
  output logic        send_signal,
  output logic        cmd_err,
  output logic [15:0] frames_sent,
  output logic [2:0]  state_dbg
);

  localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

  state_t      state;
  state_t      next_state;
  logic [15:0] to_cnt;
  logic        err;
  logic        frame_done;
  logic        is_run;
  logic        is_step;
  logic        is_dump;
  logic        is_halt;
  logic        is_bad;

  debug_cmd_decode u_decode (
    .rx_data (rx_data),
    .is_run  (is_run),
    .is_step (is_step),
    .is_dump (is_dump),
    .is_halt (is_halt),
    .is_bad  (is_bad)
  );

  always_comb begin
    next_state = state;
    err        = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_done_tick) begin
          if (is_run)       next_state = ST_RUN;
          else if (is_step) next_state = ST_STEP;
          else if (is_dump) next_state = ST_SNAP;
          err = is_bad;
        end
      end
      ST_RUN: begin
        // A halt byte coinciding with halt_req still yields a single transition.
        if (halt_req || (rx_done_tick && is_halt)) next_state = ST_SNAP;
        if (rx_done_tick && !is_halt) err = 1'b1;
      end
      ST_STEP: begin
        next_state = ST_SNAP;
        err        = rx_done_tick;
      end
      ST_SNAP: begin
        next_state = ST_SEND_REQ;
        err        = rx_done_tick;
      end
      ST_SEND_REQ: begin
        err = rx_done_tick;
        if (!tx_data_sent) begin
          next_state = ST_SEND_WAIT;
        end else if (to_cnt == TO_LAST) begin
          next_state = ST_IDLE;
          err        = 1'b1;
        end
      end
      ST_SEND_WAIT: begin
        err = rx_done_tick;
        if (tx_data_sent) begin
          next_state = ST_IDLE;
          frame_done = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs are registered decodes of the current state, one cycle behind it,
  // and drop on the same edge the FSM leaves RUN or SEND_REQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cpu_enable  <= 1'b0;
      snap_en     <= 1'b0;
      send_signal <= 1'b0;
      cmd_err     <= 1'b0;
      frames_sent <= 16'd0;
      to_cnt      <= 16'd0;
    end else begin
      state       <= next_state;
      cpu_enable  <= ((state == ST_RUN) && (next_state == ST_RUN)) || (state == ST_STEP);
      snap_en     <= (state == ST_SNAP);
      send_signal <= (state == ST_SEND_REQ) && (next_state == ST_SEND_REQ);
      cmd_err     <= err;
      to_cnt      <= ((state == ST_SEND_REQ) && (next_state == ST_SEND_REQ)) ? to_cnt + 16'd1 : 16'd0;
      if (frame_done) frames_sent <= frames_sent + 16'd1;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_debug_session_ctrl.sv
// Directed-plus-random bench for debug_session_ctrl with a session-level timing model.
module tb_debug_session_ctrl;

  localparam logic [7:0] B_RUN  = 8'h52;
  localparam logic [7:0] B_STEP = 8'h53;
  localparam logic [7:0] B_DUMP = 8'h44;
  localparam logic [7:0] B_HALT = 8'h48;
  localparam int         TMO    = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_done_tick;
  logic [7:0]  rx_data;
  logic        halt_req;
  logic        tx_data_sent;
  logic        cpu_enable;
  logic        snap_en;
  logic        send_signal;
  logic        cmd_err;
  logic [15:0] frames_sent;
  logic [2:0]  state_dbg;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_frames = 16'd0;

  debug_session_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .halt_req     (halt_req),
    .tx_data_sent (tx_data_sent),
    .cpu_enable   (cpu_enable),
    .snap_en      (snap_en),
    .send_signal  (send_signal),
    .cmd_err      (cmd_err),
    .frames_sent  (frames_sent),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One command session from the IDLE state. Cycle 0 is the cycle the byte is
  // presented; the model predicts every event cycle from the command rules.
  // stop_mode for 'R': 1 halt_req, 2 'H' byte, 3 both, applied during cycle d.
  // ack_dly < 0 models a transmitter that never acknowledges.
  task automatic session(input logic [7:0] cmd, input int stop_mode, input int d,
                         input int ack_dly, input int busy_len, input bit junk);
    int t, cpu_n, cpu_first, cpu_last, snap_n, snap_t, snap_st;
    int send_first, send_n, err_n, err_pairs, end_t, drop_t;
    int base, e_snap, e_send, e_cpu_n, e_send_n, e_end, e_err;
    bit prev_err;
    t = 0; cpu_n = 0; cpu_first = -1; cpu_last = -1; snap_n = 0; snap_t = -1;
    snap_st = -1; send_first = -1; send_n = 0; err_n = 0; err_pairs = 0;
    end_t = -1; drop_t = -1; prev_err = 1'b0;
    rx_done_tick = 1'b1;
    rx_data      = cmd;
    while (t < 4000 && end_t < 0) begin
      step();
      t++;
      rx_done_tick = 1'b0;
      if (cpu_enable) begin
        cpu_n++;
        if (cpu_first < 0) cpu_first = t;
        cpu_last = t;
      end
      if (snap_en) begin snap_n++; snap_t = t; snap_st = int'(state_dbg); end
      if (send_signal) begin send_n++; if (send_first < 0) send_first = t; end
      if (cmd_err) begin err_n++; if (prev_err) err_pairs++; end
      prev_err = cmd_err;
      if (state_dbg == 3'd0) end_t = t;
      if (cmd == B_RUN && t == d) begin
        if (stop_mode != 2) halt_req = 1'b1;
        if (stop_mode != 1) begin rx_done_tick = 1'b1; rx_data = B_HALT; end
      end
      if (junk && cmd == B_RUN && t == 2) begin rx_done_tick = 1'b1; rx_data = B_DUMP; end
      if (snap_n > 0) halt_req = 1'b0;
      if (send_first >= 0 && ack_dly >= 0 && t == send_first + ack_dly) begin
        tx_data_sent = 1'b0;
        drop_t = t;
      end
      if (junk && drop_t >= 0 && t == drop_t + 2) begin rx_done_tick = 1'b1; rx_data = B_STEP; end
      if (drop_t >= 0 && t == drop_t + busy_len) tx_data_sent = 1'b1;
    end
    halt_req     = 1'b0;
    tx_data_sent = 1'b1;

    base     = (cmd == B_RUN) ? d : ((cmd == B_STEP) ? 1 : 0);
    e_snap   = 2 + base;
    e_send   = e_snap + 1;
    e_cpu_n  = (cmd == B_RUN) ? d - 1 : ((cmd == B_STEP) ? 1 : 0);
    e_err    = (junk && cmd == B_RUN) ? 1 : 0;
    if (ack_dly >= 0) begin
      e_send_n = ack_dly + 1;
      e_end    = e_send + ack_dly + busy_len + 1;
      exp_frames = exp_frames + 16'd1;
      if (junk) e_err++;
    end else begin
      e_send_n = TMO - 1;
      e_end    = e_send + TMO - 1;
      e_err++;
    end

    chk("session_end_reached", (end_t >= 0), 1);
    chk("cpu_enable_cycles", cpu_n, e_cpu_n);
    if (e_cpu_n > 0) begin
      chk("cpu_enable_first", cpu_first, 2);
      chk("cpu_enable_last", cpu_last, (cmd == B_RUN) ? d : 2);
    end
    chk("snap_en_pulses", snap_n, 1);
    chk("snap_en_cycle", snap_t, e_snap);
    chk("state_at_snap", snap_st, 4);
    chk("send_signal_first", send_first, e_send);
    chk("send_signal_cycles", send_n, e_send_n);
    chk("idle_return_cycle", end_t, e_end);
    chk("cmd_err_pulses", err_n, e_err);
    chk("cmd_err_back_to_back", err_pairs, 0);
    chk("frames_sent", frames_sent, exp_frames);
    chk("cpu_enable_at_end", cpu_enable, 0);
  endtask

  initial begin
    logic [7:0] b;
    int         k;
    reset        = 1'b1;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
    halt_req     = 1'b0;
    tx_data_sent = 1'b1;
    repeat (3) step();
    chk("rst_state", state_dbg, 0);
    chk("rst_cpu_enable", cpu_enable, 0);
    chk("rst_snap_en", snap_en, 0);
    chk("rst_send_signal", send_signal, 0);
    chk("rst_cmd_err", cmd_err, 0);
    chk("rst_frames_sent", frames_sent, 0);
    reset = 1'b0;
    step();

    // Unknown bytes in IDLE give a single error pulse and change nothing.
    for (int i = 0; i < 4; i++) begin
      b = (i == 0) ? 8'h7A : 8'($urandom_range(0, 255));
      while (b == B_RUN || b == B_STEP || b == B_DUMP || b == B_HALT) b = 8'($urandom_range(0, 255));
      rx_done_tick = 1'b1; rx_data = b;
      step();
      rx_done_tick = 1'b0;
      chk("bad_byte_err_pulse", cmd_err, 1);
      chk("bad_byte_state", state_dbg, 0);
      step();
      chk("bad_byte_err_drop", cmd_err, 0);
      chk("bad_byte_no_run", cpu_enable | snap_en | send_signal, 0);
    end
    rx_done_tick = 1'b1; rx_data = B_HALT;
    step();
    rx_done_tick = 1'b0;
    chk("halt_in_idle_no_err", cmd_err, 0);
    chk("halt_in_idle_state", state_dbg, 0);
    step();

    session(B_DUMP, 0, 0, 5, 300, 1'b0);
    session(B_STEP, 0, 0, $urandom_range(0, 8), $urandom_range(3, 40), 1'b0);
    session(B_RUN, 1, 51, 3, 20, 1'b0);
    session(B_RUN, 2, 20, 2, 15, 1'b0);
    session(B_RUN, 3, $urandom_range(3, 30), 1, 10, 1'b0);
    halt_req = 1'b1;
    session(B_RUN, 1, 1, 0, 5, 1'b0);
    session(B_DUMP, 0, 0, 4, 12, 1'b1);
    session(B_RUN, 1, $urandom_range(4, 25), 2, 9, 1'b1);

    for (int i = 0; i < 6; i++) begin
      k = $urandom_range(0, 2);
      b = (k == 0) ? B_DUMP : ((k == 1) ? B_STEP : B_RUN);
      session(b, $urandom_range(1, 3), $urandom_range(4, 40), $urandom_range(0, 10),
              $urandom_range(4, 60), 1'($urandom_range(0, 1)));
    end

    session(B_DUMP, 0, 0, -1, 0, 1'b0);

    // Reset while the frame is still leaving the UART.
    rx_done_tick = 1'b1; rx_data = B_DUMP;
    k = 0;
    step();
    rx_done_tick = 1'b0;
    while (!send_signal && k < 20) begin step(); k++; end
    tx_data_sent = 1'b0;
    k = 0;
    while (state_dbg != 3'd5 && k < 20) begin step(); k++; end
    chk("reached_send_wait", state_dbg, 5);
    reset = 1'b1;
    step();
    chk("midrst_state", state_dbg, 0);
    chk("midrst_outputs", {cpu_enable, snap_en, send_signal, cmd_err}, 0);
    chk("midrst_frames", frames_sent, 0);
    reset        = 1'b0;
    tx_data_sent = 1'b1;
    exp_frames   = 16'd0;
    step();
    step();
    chk("post_rst_idle", state_dbg, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
